// File: rtl/mult_accumulator_if.sv
// Handshake bundle for mult_accumulator: product input stream, result output stream and abort.
interface mult_accumulator_if #(
  parameter int ACC_W = 12
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       product;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;
  logic [3:0]       count;

  modport master (
    output clear, in_valid, product, out_ready,
    input  in_ready, out_valid, acc_out, overflow, count
  );

  modport slave (
    input  clear, in_valid, product, out_ready,
    output in_ready, out_valid, acc_out, overflow, count
  );
endinterface

// File: rtl/mult_accumulator.sv
// Sums N_TERMS consecutive 8-bit products into an ACC_W-bit total and hands the
// result downstream over a valid/ready handshake.
module mult_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  mult_accumulator_if.slave bus
);
  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [3:0] LAST_IDX = 4'(N_TERMS - 1);
  localparam logic [3:0] FULL_CNT = 4'(N_TERMS);

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_out_q;
  logic [ACC_W-1:0] sum;
  logic [3:0]       count_q;
  logic             overflow_q;
  logic             out_valid_q;
  logic             ready;
  logic             accept;
  logic             final_term;
  logic             carry;

  assign {carry, sum} = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, bus.product};

  // in_ready depends on state alone, so out_ready never reaches it combinationally.
  assign ready         = (state == ACCUM);
  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.count     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    final_term = 1'b0;
    case (state)
      ACCUM: begin
        accept     = bus.in_valid && ready && !bus.clear;
        final_term = accept && (count_q == LAST_IDX);
        if (final_term) state_next = HOLD;
      end
      HOLD: begin
        if (bus.clear || bus.out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  // Clear discards the partial sum and any pending result but leaves acc_out untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      acc_out_q   <= '0;
      count_q     <= 4'd0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.clear) begin
      acc         <= '0;
      count_q     <= 4'd0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      overflow_q <= overflow_q | carry;
      if (final_term) begin
        acc_out_q   <= sum;
        out_valid_q <= 1'b1;
        acc         <= '0;
        count_q     <= FULL_CNT;
      end else begin
        acc     <= sum;
        count_q <= count_q + 4'd1;
      end
    end else if (state == HOLD && bus.out_ready) begin
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= 4'd0;
    end
  end
endmodule

// File: tb/tb_mult_accumulator.sv
// Randomised and directed bench for mult_accumulator; two instances (4 terms / 12 bits and
// 2 terms / 8 bits) share one stimulus stream and are each checked against a sum-of-products model.
module tb_mult_accumulator;
  localparam int NA = 4;
  localparam int WA = 12;
  localparam int NB = 2;
  localparam int WB = 8;

  typedef struct {
    int acc;
    int ovf;
  } res_t;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       clear     = 1'b0;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] product   = 8'd0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_accumulator_if #(.ACC_W(WA)) bus_a ();
  mult_accumulator_if #(.ACC_W(WB)) bus_b ();

  assign bus_a.clear     = clear;
  assign bus_a.in_valid  = in_valid;
  assign bus_a.product   = product;
  assign bus_a.out_ready = out_ready;
  assign bus_b.clear     = clear;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.product   = product;
  assign bus_b.out_ready = out_ready;

  mult_accumulator #(.N_TERMS(NA), .ACC_W(WA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mult_accumulator #(.N_TERMS(NB), .ACC_W(WB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic [15:0] obs_acc   [2];
  logic        obs_valid [2];
  logic        obs_ready [2];
  logic        obs_ovf   [2];
  logic [3:0]  obs_cnt   [2];

  assign obs_acc[0]   = 16'(bus_a.acc_out);
  assign obs_acc[1]   = 16'(bus_b.acc_out);
  assign obs_valid[0] = bus_a.out_valid;
  assign obs_valid[1] = bus_b.out_valid;
  assign obs_ready[0] = bus_a.in_ready;
  assign obs_ready[1] = bus_b.in_ready;
  assign obs_ovf[0]   = bus_a.overflow;
  assign obs_ovf[1]   = bus_b.overflow;
  assign obs_cnt[0]   = bus_a.count;
  assign obs_cnt[1]   = bus_b.count;

  // Model: the products accepted toward the current result, kept as a plain running total.
  int   n_terms [2] = '{NA, NB};
  int   acc_w   [2] = '{WA, WB};
  int   m_hold  [2] = '{0, 0};
  int   m_cnt   [2] = '{0, 0};
  int   m_psum  [2] = '{0, 0};
  int   m_last  [2] = '{0, 0};
  res_t q_a[$];
  res_t q_b[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int q_size(input int i);
    return (i == 0) ? q_a.size() : q_b.size();
  endfunction

  function automatic res_t q_front(input int i);
    return (i == 0) ? q_a[0] : q_b[0];
  endfunction

  task automatic q_push(input int i, input res_t r);
    if (i == 0) q_a.push_back(r);
    else        q_b.push_back(r);
  endtask

  task automatic q_drop(input int i);
    if (i == 0) q_a.delete(0);
    else        q_b.delete(0);
  endtask

  // Monitor: compares each cycle's outputs, pops the scoreboard on every result handshake,
  // then advances the model to the state expected after the coming rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   md;
      res_t r;
      md = 1 << acc_w[i];
      if (!rst_n) begin
        m_hold[i] = 0;
        m_cnt[i]  = 0;
        m_psum[i] = 0;
        m_last[i] = 0;
        if (i == 0) q_a.delete();
        else        q_b.delete();
      end
      checkOutput($sformatf("in_ready[%0d]", i), int'(obs_ready[i]), m_hold[i] ? 0 : 1);
      checkOutput($sformatf("out_valid[%0d]", i), int'(obs_valid[i]), m_hold[i]);
      checkOutput($sformatf("count[%0d]", i), int'(obs_cnt[i]), m_hold[i] ? n_terms[i] : m_cnt[i]);
      checkOutput($sformatf("acc_out[%0d]", i), int'(obs_acc[i]), m_last[i]);
      if (m_hold[i] && q_size(i) > 0) begin
        r = q_front(i);
        checkOutput($sformatf("overflow[%0d]", i), int'(obs_ovf[i]), r.ovf);
      end else begin
        checkOutput($sformatf("overflow[%0d]", i), int'(obs_ovf[i]), (m_psum[i] >= md) ? 1 : 0);
      end
      if (rst_n) begin
        if (obs_valid[i] && out_ready && !clear) begin
          if (q_size(i) == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL result_present[%0d]: got a result, expected none", i);
          end else begin
            r = q_front(i);
            checkOutput($sformatf("result_acc[%0d]", i), int'(obs_acc[i]), r.acc);
            checkOutput($sformatf("result_ovf[%0d]", i), int'(obs_ovf[i]), r.ovf);
            q_drop(i);
          end
        end
        if (clear) begin
          if (m_hold[i] && q_size(i) > 0) q_drop(i);
          m_hold[i] = 0;
          m_cnt[i]  = 0;
          m_psum[i] = 0;
        end else if (m_hold[i]) begin
          if (out_ready) begin
            if (!obs_valid[i] && q_size(i) > 0) q_drop(i);
            m_hold[i] = 0;
            m_cnt[i]  = 0;
          end
        end else if (in_valid) begin
          m_psum[i] = m_psum[i] + int'(product);
          m_cnt[i]  = m_cnt[i] + 1;
          if (m_cnt[i] == n_terms[i]) begin
            r.acc     = m_psum[i] % md;
            r.ovf     = (m_psum[i] >= md) ? 1 : 0;
            q_push(i, r);
            m_last[i] = r.acc;
            m_hold[i] = 1;
            m_cnt[i]  = 0;
            m_psum[i] = 0;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [7:0] p, input logic ordy, input logic clr);
    @(posedge clk);
    #1;
    in_valid  = v;
    product   = p;
    out_ready = ordy;
    clear     = clr;
  endtask

  // Reset lands mid-cycle so the asynchronous path is what clears the outputs.
  task automatic doReset();
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("rst_out_valid[%0d]", i), int'(obs_valid[i]), 0);
      checkOutput($sformatf("rst_acc_out[%0d]", i), int'(obs_acc[i]), 0);
      checkOutput($sformatf("rst_count[%0d]", i), int'(obs_cnt[i]), 0);
      checkOutput($sformatf("rst_overflow[%0d]", i), int'(obs_ovf[i]), 0);
      checkOutput($sformatf("rst_in_ready[%0d]", i), int'(obs_ready[i]), 1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic       vpat [7];
    logic [7:0] ppat [4];
    int         k;
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    ppat = '{8'd10, 8'd20, 8'd30, 8'd40};

    doReset();

    // Four back-to-back 225s with the consumer always ready.
    for (int j = 0; j < 4; j++) applyStimulus(1'b1, 8'd225, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("a_900_visible", int'(obs_acc[0]), 900);
    checkOutput("a_900_valid", int'(obs_valid[0]), 1);
    for (int j = 0; j < 3; j++) applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("a_900_kept", int'(obs_acc[0]), 900);

    // Backpressure: products offered during HOLD must be ignored.
    doReset();
    for (int j = 0; j < 4; j++) applyStimulus(1'b1, 8'd225, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) applyStimulus(1'b1, 8'd7, 1'b0, 1'b0);
    checkOutput("bp_count", int'(obs_cnt[0]), 4);
    checkOutput("bp_acc", int'(obs_acc[0]), 900);
    for (int j = 0; j < 3; j++) applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

    // Narrow instance: 200 + 100 wraps to 44 with overflow, then 1 + 2 = 3 clean.
    doReset();
    applyStimulus(1'b1, 8'd200, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd100, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("b_wrap_acc", int'(obs_acc[1]), 44);
    checkOutput("b_wrap_ovf", int'(obs_ovf[1]), 1);
    applyStimulus(1'b1, 8'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("b_small_acc", int'(obs_acc[1]), 3);
    checkOutput("b_small_ovf", int'(obs_ovf[1]), 0);

    // Gapped in_valid pattern.
    doReset();
    k = 0;
    for (int j = 0; j < 7; j++) begin
      applyStimulus(vpat[j], vpat[j] ? ppat[k] : 8'd99, 1'b0, 1'b0);
      if (vpat[j]) k++;
    end
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("gap_acc", int'(obs_acc[0]), 100);
    checkOutput("gap_count", int'(obs_cnt[0]), 4);
    for (int j = 0; j < 3; j++) applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

    // Clear drops a partial sum, then a pending result.
    doReset();
    applyStimulus(1'b1, 8'd50, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd50, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd9, 1'b1, 1'b1);
    for (int j = 0; j < 4; j++) applyStimulus(1'b1, 8'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("clr_acc", int'(obs_acc[0]), 4);
    checkOutput("clr_ovf", int'(obs_ovf[0]), 0);
    for (int j = 0; j < 4; j++) applyStimulus(1'b1, 8'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("clr_hold_valid", int'(obs_valid[0]), 0);

    // Asynchronous reset mid-accumulation and mid-HOLD.
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0);
    doReset();
    for (int j = 0; j < 4; j++) applyStimulus(1'b1, 8'd5, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    doReset();
    for (int j = 0; j < 4; j++) applyStimulus(1'b1, 8'd5, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("post_rst_acc", int'(obs_acc[0]), 20);

    // Random traffic with occasional clears and resets.
    for (int j = 0; j < 600; j++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset();
      end else begin
        applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                      ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
      end
    end

    for (int j = 0; j < 4; j++) applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("drain_a", q_a.size(), 0);
    checkOutput("drain_b", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
